// File: rtl/data_memory_responder.sv
// Data-memory responder for the single-cycle core: word RAM, output FIFO,
// status register and free-running cycle counter behind one load/store port.
module data_memory_responder #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        write_memory,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [31:0]      RAM_BYTES   = 32'(RAM_WORDS * 4);
  localparam logic [29:0]      OUT_WORD    = 30'h2000_0000;
  localparam logic [29:0]      STATUS_WORD = 30'h2000_0001;
  localparam logic [29:0]      CYCLE_WORD  = 30'h2000_0002;
  localparam logic [CNT_W-1:0] DEPTH_CNT   = CNT_W'(FIFO_DEPTH);

  // Address decode (byte offset ignored)
  logic              w_sel_ram;
  logic              w_sel_out;
  logic              w_sel_status;
  logic              w_sel_cycle;
  logic [RAM_AW-1:0] w_ram_idx;
  logic              w_store;

  assign w_sel_ram    = (address < RAM_BYTES);
  assign w_sel_out    = (address[31:2] == OUT_WORD);
  assign w_sel_status = (address[31:2] == STATUS_WORD);
  assign w_sel_cycle  = (address[31:2] == CYCLE_WORD);
  assign w_ram_idx    = address[RAM_AW+1:2];
  // Stores arriving on an edge while reset is held are dropped everywhere.
  assign w_store      = write_memory && !reset;

  // Word RAM: no reset, contents undefined until written
  logic [31:0] r_ram [RAM_WORDS];

  always_ff @(posedge clock) begin
    if (w_store && w_sel_ram) begin
      r_ram[w_ram_idx] <= write_data;
    end
  end

  // Output FIFO.
  // Handshake: out_valid is high whenever the FIFO holds a word and never
  // depends on out_ready; a word leaves on a rising edge where out_valid and
  // out_ready are both high, and out_data is stable until that edge.
  logic [31:0]      r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_push_ok;
  logic             w_overflow_set;
  logic             w_status_wr;
  logic [CNT_W-1:0] w_count_next;
  logic [31:0]      w_status;

  assign w_full         = (r_count == DEPTH_CNT);
  assign w_empty        = (r_count == '0);
  assign w_push         = w_store && w_sel_out;
  assign w_pop          = out_valid && out_ready;
  // A pop on the same edge frees the slot the push needs.
  assign w_push_ok      = w_push && (!w_full || w_pop);
  assign w_overflow_set = w_push && !w_push_ok;
  assign w_status_wr    = w_store && w_sel_status;

  always_comb begin
    w_count_next = r_count;
    case ({w_push_ok, w_pop})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_push_ok) begin
      r_fifo[r_wr_ptr] <= write_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= w_count_next;
    end
  end

  assign out_valid = !w_empty;
  assign out_data  = out_valid ? r_fifo[r_rd_ptr] : 32'h0;

  // Sticky overflow: a rejected push outranks a clearing status write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_overflow_set) begin
      r_overflow <= 1'b1;
    end else if (w_status_wr) begin
      r_overflow <= 1'b0;
    end
  end

  assign w_status = {r_overflow, w_full, w_empty, {(29 - CNT_W){1'b0}}, r_count};

  // Free-running cycle counter; a store replaces the increment on that edge
  logic [31:0] r_cycle;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cycle <= 32'h0;
    end else if (w_store && w_sel_cycle) begin
      r_cycle <= write_data;
    end else begin
      r_cycle <= r_cycle + 32'h1;
    end
  end

  // Zero-latency load path
  always_comb begin
    read_data = 32'h0;
    if (w_sel_ram) begin
      read_data = r_ram[w_ram_idx];
    end else if (w_sel_status) begin
      read_data = w_status;
    end else if (w_sel_cycle) begin
      read_data = r_cycle;
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: directed vector table, async-reset
// sequence and randomized traffic against a queue-based reference model.
module tb_data_memory_responder;

  localparam int RAM_WORDS  = 64;
  localparam int FIFO_DEPTH = 4;

  localparam logic [31:0] A_OUT = 32'h8000_0000;
  localparam logic [31:0] A_ST  = 32'h8000_0004;
  localparam logic [31:0] A_CY  = 32'h8000_0008;
  localparam logic [31:0] A_UNM = 32'h4000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        write_memory;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;

  data_memory_responder #(
    .RAM_WORDS (RAM_WORDS),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .write_memory(write_memory),
    .address     (address),
    .write_data  (write_data),
    .read_data   (read_data),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready)
  );

  // Clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: FIFO contents live in the scoreboard queue exp_q
  logic [31:0] exp_q[$];
  logic [31:0] m_ram[RAM_WORDS];
  bit          m_ram_ok[RAM_WORDS];
  bit          m_ovf;
  logic [31:0] m_cycle;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    return {m_ovf, exp_q.size() == FIFO_DEPTH, exp_q.size() == 0, 29'(exp_q.size())};
  endfunction

  function automatic bit m_read(input logic [31:0] a, output logic [31:0] v);
    logic [31:0] aw;
    aw = a & ~32'h3;
    v  = 32'h0;
    if (a < RAM_WORDS * 4) begin
      v = m_ram[a >> 2];
      return m_ram_ok[a >> 2];
    end
    if (aw == A_ST) v = m_status();
    else if (aw == A_CY) v = m_cycle;
    return 1'b1;
  endfunction

  task automatic m_reset();
    exp_q.delete();
    m_ovf   = 1'b0;
    m_cycle = 32'h0;
  endtask

  task automatic m_edge(input bit wm, input logic [31:0] a, input logic [31:0] wd, input bit rdy);
    logic [31:0] aw;
    int          n_before;
    bit          pop;
    aw       = a & ~32'h3;
    n_before = exp_q.size();
    pop      = (n_before != 0) && rdy;
    if (pop) void'(exp_q.pop_front());
    if (wm && aw == A_OUT) begin
      if (n_before < FIFO_DEPTH || pop) exp_q.push_back(wd);
      else m_ovf = 1'b1;
    end else if (wm && aw == A_ST) begin
      m_ovf = 1'b0;
    end
    if (wm && aw == A_CY) m_cycle = wd;
    else m_cycle = m_cycle + 32'h1;
    if (wm && a < RAM_WORDS * 4) begin
      m_ram[a >> 2]    = wd;
      m_ram_ok[a >> 2] = 1'b1;
    end
  endtask

  // Driver tasks: inputs change 1ns after posedge, outputs sampled at negedge
  task automatic drive(input bit wm, input logic [31:0] a, input logic [31:0] wd, input bit rdy);
    write_memory = wm;
    address      = a;
    write_data   = wd;
    out_ready    = rdy;
  endtask

  task automatic step(input string tag, input bit wm, input logic [31:0] a,
                      input logic [31:0] wd, input bit rdy);
    logic [31:0] v;
    drive(wm, a, wd, rdy);
    @(negedge clock);
    check({tag, "_valid"}, {31'h0, out_valid}, {31'h0, exp_q.size() != 0});
    check({tag, "_odata"}, out_data, (exp_q.size() != 0) ? exp_q[0] : 32'h0);
    if (m_read(a, v)) check({tag, "_rd"}, read_data, v);
    @(posedge clock);
    m_edge(wm, a, wd, rdy);
    #1;
  endtask

  // Directed vector table
  typedef struct {
    bit          wm;
    logic [31:0] addr;
    logic [31:0] wd;
    bit          rdy;
    bit          chk_rd;
    logic [31:0] rd;
    bit          valid;
    logic [31:0] odata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit wm, input logic [31:0] addr, input logic [31:0] wd,
                              input bit rdy, input bit chk_rd, input logic [31:0] rd,
                              input bit valid, input logic [31:0] odata);
    vec_t v;
    v.wm = wm; v.addr = addr; v.wd = wd; v.rdy = rdy;
    v.chk_rd = chk_rd; v.rd = rd; v.valid = valid; v.odata = odata;
    return v;
  endfunction

  initial begin
    logic [31:0] v;
    logic [31:0] a;
    bit          wm;
    bit          rdy;
    int          sel;

    // Reset block
    reset = 1'b1;
    drive(1'b0, A_ST, 32'h0, 1'b0);
    #1;
    check("reset_status", read_data, 32'h2000_0000);
    check("reset_valid", {31'h0, out_valid}, 32'h0);
    check("reset_odata", out_data, 32'h0);
    address = A_CY;
    #1;
    check("reset_cycle", read_data, 32'h0);
    address = A_UNM;
    #1;
    check("reset_unmapped", read_data, 32'h0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    m_reset();

    vecs.push_back(mk(1, 32'h10, 32'h1111_1111, 0, 0, 32'h0,         0, 32'h0));
    vecs.push_back(mk(1, 32'h10, 32'hDEAD_BEEF, 0, 1, 32'h1111_1111, 0, 32'h0));
    vecs.push_back(mk(0, 32'h10, 32'h0,         0, 1, 32'hDEAD_BEEF, 0, 32'h0));
    vecs.push_back(mk(0, 32'h13, 32'h0,         0, 1, 32'hDEAD_BEEF, 0, 32'h0));
    vecs.push_back(mk(0, A_ST,   32'h0,         1, 1, 32'h2000_0000, 0, 32'h0));
    vecs.push_back(mk(1, A_OUT,  32'h1,         0, 1, 32'h0,         0, 32'h0));
    vecs.push_back(mk(1, A_OUT,  32'h2,         0, 1, 32'h0,         1, 32'h1));
    vecs.push_back(mk(1, A_OUT,  32'h3,         0, 1, 32'h0,         1, 32'h1));
    vecs.push_back(mk(1, A_OUT,  32'h4,         0, 1, 32'h0,         1, 32'h1));
    vecs.push_back(mk(0, A_ST,   32'h0,         0, 1, 32'h4000_0004, 1, 32'h1));
    vecs.push_back(mk(1, A_OUT,  32'h5,         0, 1, 32'h0,         1, 32'h1));
    vecs.push_back(mk(0, A_ST,   32'h0,         0, 1, 32'hC000_0004, 1, 32'h1));
    vecs.push_back(mk(1, A_OUT,  32'h8,         1, 1, 32'h0,         1, 32'h1));
    vecs.push_back(mk(1, A_ST,   32'h0,         0, 1, 32'hC000_0004, 1, 32'h2));
    vecs.push_back(mk(0, A_ST,   32'h0,         0, 1, 32'h4000_0004, 1, 32'h2));
    vecs.push_back(mk(1, A_OUT,  32'h9,         1, 1, 32'h0,         1, 32'h2));
    vecs.push_back(mk(0, A_ST,   32'h0,         0, 1, 32'h4000_0004, 1, 32'h3));
    vecs.push_back(mk(0, 32'h10, 32'h0,         1, 1, 32'hDEAD_BEEF, 1, 32'h3));
    vecs.push_back(mk(0, A_ST,   32'h0,         1, 1, 32'h0000_0003, 1, 32'h4));
    vecs.push_back(mk(0, 32'h10, 32'h0,         1, 1, 32'hDEAD_BEEF, 1, 32'h8));
    vecs.push_back(mk(0, A_ST,   32'h0,         1, 1, 32'h0000_0001, 1, 32'h9));
    vecs.push_back(mk(0, A_ST,   32'h0,         1, 1, 32'h2000_0000, 0, 32'h0));
    vecs.push_back(mk(1, A_CY,   32'hFFFF_FFFE, 0, 0, 32'h0,         0, 32'h0));
    vecs.push_back(mk(0, A_CY,   32'h0,         0, 1, 32'hFFFF_FFFE, 0, 32'h0));
    vecs.push_back(mk(0, A_CY,   32'h0,         0, 1, 32'hFFFF_FFFF, 0, 32'h0));
    vecs.push_back(mk(0, A_CY,   32'h0,         0, 1, 32'h0000_0000, 0, 32'h0));
    vecs.push_back(mk(1, A_UNM,  32'h1234_5678, 0, 1, 32'h0,         0, 32'h0));
    vecs.push_back(mk(0, A_UNM,  32'h0,         0, 1, 32'h0,         0, 32'h0));
    vecs.push_back(mk(0, A_ST,   32'h0,         0, 1, 32'h2000_0000, 0, 32'h0));
    vecs.push_back(mk(0, 32'h10, 32'h0,         0, 1, 32'hDEAD_BEEF, 0, 32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].wm, vecs[i].addr, vecs[i].wd, vecs[i].rdy);
      @(negedge clock);
      if (vecs[i].chk_rd) check($sformatf("vec%0d_rd", i), read_data, vecs[i].rd);
      check($sformatf("vec%0d_valid", i), {31'h0, out_valid}, {31'h0, vecs[i].valid});
      check($sformatf("vec%0d_odata", i), out_data, vecs[i].odata);
      @(posedge clock);
      m_edge(vecs[i].wm, vecs[i].addr, vecs[i].wd, vecs[i].rdy);
      #1;
    end

    // Async reset with three words queued and a RAM store held across the reset edge
    step("pre_rst0", 1'b1, A_OUT, 32'hA0, 1'b0);
    step("pre_rst1", 1'b1, A_OUT, 32'hA1, 1'b0);
    step("pre_rst2", 1'b1, A_OUT, 32'hA2, 1'b0);
    drive(1'b0, A_ST, 32'h0, 1'b0);
    #2;
    check("pre_rst_status", read_data, 32'h0000_0003);
    reset = 1'b1;
    #1;
    check("async_rst_valid", {31'h0, out_valid}, 32'h0);
    check("async_rst_odata", out_data, 32'h0);
    check("async_rst_status", read_data, 32'h2000_0000);
    address = A_CY;
    #1;
    check("async_rst_cycle", read_data, 32'h0);
    m_reset();
    drive(1'b1, 32'h10, 32'hBAD0_BAD0, 1'b1);
    @(posedge clock);
    #1;
    drive(1'b1, A_OUT, 32'hBAD1, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    step("post_rst_ram", 1'b0, 32'h10, 32'h0, 1'b0);
    step("post_rst_cycle", 1'b0, A_CY, 32'h0, 1'b0);
    step("post_rst_status", 1'b0, A_ST, 32'h0, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3: a = ($urandom_range(0, RAM_WORDS - 1) << 2) | $urandom_range(0, 3);
        4, 5:       a = A_OUT | $urandom_range(0, 3);
        6, 9:       a = A_ST | $urandom_range(0, 3);
        7:          a = A_CY;
        default:    a = ($urandom & 32'h7FFF_FFFC) | 32'h0000_0100;
      endcase
      wm  = ($urandom_range(0, 2) != 0);
      if (sel == 7) wm = ($urandom_range(0, 7) == 0);
      rdy = ((i / 100) % 2 == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      step($sformatf("rnd%0d", i), wm, a, $urandom, rdy);
    end

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Responder for the single-cycle core's data-memory port: the core drives address (its ALU result), write_data and write_memory; this block returns read_data in the same cycle.
- Contains a word RAM and three memory-mapped peripherals:
  - a write-only output FIFO that streams core writes to an external valid/ready consumer;
  - a status register;
  - a free-running cycle counter.
- Sits beside the core at top level; its read_data feeds the core's read_data input.

Parameters:
- RAM_WORDS, 64, number of 32-bit RAM words; power of 2, ≥2.
- FIFO_DEPTH, 4, output FIFO entries; power of 2, ≥2.

Ports:
- clock  input  1  rising-edge clock shared with the core.
- reset  input  1  asynchronous, active-high reset.
- write_memory  input  1  store strobe from the core; acts on the rising edge.
- address  input  32  byte address from the core's ALU result.
- write_data  input  32  store data from the core.
- read_data  output  32  combinational load data for the current address.
- out_valid  output  1  FIFO head is valid.
- out_data  output  32  FIFO head word; 0 when out_valid=0.
- out_ready  input  1  consumer accepts the head this cycle.

Behaviour:
- Address decode: address[1:0] is ignored (word access only).
  - RAM: address < RAM_WORDS*4, index = address[log2(RAM_WORDS)+1:2].
  - OUT_DATA: 0x8000_0000.
  - STATUS: 0x8000_0004.
  - CYCLE: 0x8000_0008.
  - Any other address: reads return 0, writes are ignored.
- read_data is purely combinational from address and current state (zero-latency, as the single-cycle core requires). A same-cycle write is not visible until after the edge; read_data shows the old value.
- RAM:
  - Write on the rising edge when write_memory=1 and the address decodes to RAM.
  - Contents are not reset and are X until written.
- OUT_DATA reads return 0.
- FIFO push: write_memory=1 && address==OUT_DATA; pushes write_data.
- FIFO pop: out_valid && out_ready.
- Push acceptance: accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle (full + push + pop → count unchanged, the new word enters at the tail).
  - A rejected push discards the data and sets the sticky overflow flag.
- Simultaneous push+pop when not full: count unchanged, order preserved.
- Empty: out_valid=0, out_data=0, and out_ready is ignored.
- Pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH (width log2(FIFO_DEPTH)+1).
- out_valid = (count!=0). out_data = head entry, driven from registered storage (no combinational path from write_data).
- STATUS read layout:
  - [31] overflow;
  - [30] full (count==FIFO_DEPTH);
  - [29] empty;
  - [log2(FIFO_DEPTH):0] count;
  - all other bits 0.
- STATUS write: any write clears overflow. If the same edge has a rejected push, set wins.
- CYCLE:
  - 32-bit counter; increments by 1 every cycle; wraps 0xFFFF_FFFF→0.
  - A write loads write_data exactly; there is no increment on that edge.
  - A read returns the current value.
- Reset (asynchronous, immediate):
  - count=0, pointers=0, overflow=0, CYCLE=0, out_valid=0, out_data=0.
  - read_data follows decode: STATUS reads 0x2000_0000 (empty=1), CYCLE reads 0, unmapped addresses read 0, RAM reads X.
  - RAM is not cleared.
- Reset asserted mid-stream: queued FIFO words are lost. Any store in progress on an edge during reset is ignored, including RAM writes.

Test Plan:
- RAM: write 0xDEAD_BEEF to 0x10, next cycle read 0x10 and 0x13 → 0xDEAD_BEEF. In the write cycle itself, read_data shows the prior value.
- FIFO fill/drain: out_ready=0, push 1,2,3,4 → STATUS=0x4000_0004, out_data=1. Push 5 → dropped, STATUS=0xC000_0004. Drain with out_ready=1 → 1,2,3,4 on consecutive cycles, then out_valid=0, out_data=0.
- Full with simultaneous push 9 and pop → count stays 4, overflow stays 0, drained order ends with ...,9.
- Overflow clear: write STATUS with overflow set → bit 31=0. Same edge as a rejected push → bit 31 remains 1.
- CYCLE: write 0xFFFF_FFFE → reads 0xFFFF_FFFE, then 0xFFFF_FFFF, then 0 on successive cycles.
- Async reset mid-operation: 3 words queued, assert reset between edges → out_valid=0 and STATUS=0x2000_0000 immediately. Unmapped address 0x4000_0000 reads 0 and a write to it changes nothing.
